// File: rtl/imm_gen_stage_if.sv
// ----------------------------------------------------------------------------
// imm_gen_stage_if
// Bundle of the handshake, data and control signals of imm_gen_stage.
//   Upstream side   : in_valid, in_ready, inst_code, pc_in
//   Downstream side : out_valid, out_ready, imm_out, fmt, illegal, pc_out
//   Control/status  : flush, cnt_clr, illegal_cnt
// Modports:
//   slave  - the stage itself (consumes instructions, produces immediates)
//   master - the environment (fetch on the input side, ALU on the output side)
// ----------------------------------------------------------------------------
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst_code;
    logic [PC_W-1:0]   pc_in;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   imm_out;
    logic [2:0]        fmt;
    logic              illegal;
    logic [PC_W-1:0]   pc_out;
    logic              cnt_clr;
    logic [CNT_W-1:0]  illegal_cnt;

    modport slave (
        input  flush, in_valid, inst_code, pc_in, out_ready, cnt_clr,
        output in_ready, out_valid, imm_out, fmt, illegal, pc_out, illegal_cnt
    );

    modport master (
        output flush, in_valid, inst_code, pc_in, out_ready, cnt_clr,
        input  in_ready, out_valid, imm_out, fmt, illegal, pc_out, illegal_cnt
    );
endinterface

// File: rtl/imm_gen_stage.sv
// ----------------------------------------------------------------------------
// imm_gen_stage
// Registered RV32I/RV64I immediate generator with valid/ready on both sides.
// Each accepted instruction is decoded into an XLEN-wide immediate, a 3-bit
// format code (0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 illegal) and an
// illegal flag, then held in an output register. A second (skid) register
// absorbs the one entry that can arrive while the output is stalled, which
// lets in_ready be a flop. A saturating counter tallies delivered illegals.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - imm_gen_stage_if.slave (handshake, data, flush, cnt_clr, counter)
// The XLEN/PC_W/CNT_W parameters must match those of the connected interface.
// ----------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    imm_gen_stage_if.slave      bus
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Decode one instruction word into {fmt, imm}.
    function automatic logic [XLEN+2:0] f_decode(input logic [31:0] inst);
        logic [XLEN-1:0] v_imm;
        logic [2:0]      v_fmt;
        logic [5:0]      v_sh;
        v_imm = {XLEN{1'b0}};
        v_fmt = FMT_ILL;
        // RV64 shifts use a 6-bit shamt; RV32 only inst[24:20].
        v_sh  = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
        if (inst[1:0] != 2'b11) begin
            v_fmt = FMT_ILL;
            v_imm = {XLEN{1'b0}};
        end else begin
            case (inst[6:0])
                7'b0000011, 7'b1100111: begin
                    v_fmt = FMT_I;
                    v_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
                end
                7'b0010011: begin
                    v_fmt = FMT_I;
                    if ((inst[14:12] == 3'b001) || (inst[14:12] == 3'b101)) begin
                        v_imm = {{(XLEN-6){1'b0}}, v_sh};
                    end else begin
                        v_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
                    end
                end
                7'b0100011: begin
                    v_fmt = FMT_S;
                    v_imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
                end
                7'b1100011: begin
                    v_fmt = FMT_B;
                    v_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                             inst[30:25], inst[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    v_fmt = FMT_U;
                    // Sign-extend the 20-bit field, then shift: the bits
                    // pushed out at the top are copies of inst[31].
                    v_imm = {{(XLEN-20){inst[31]}}, inst[31:12]} << 4'd12;
                end
                7'b1101111: begin
                    v_fmt = FMT_J;
                    v_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                             inst[20], inst[30:21], 1'b0};
                end
                7'b1110011: begin
                    v_fmt = FMT_Z;
                    v_imm = {{(XLEN-12){1'b0}}, inst[31:20]};
                end
                7'b0110011, 7'b0001111: begin
                    v_fmt = FMT_R;
                    v_imm = {XLEN{1'b0}};
                end
                default: begin
                    v_fmt = FMT_ILL;
                    v_imm = {XLEN{1'b0}};
                end
            endcase
        end
        return {v_fmt, v_imm};
    endfunction

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_imm;
    logic [2:0]        r_out_fmt;
    logic              r_out_ill;
    logic [PC_W-1:0]   r_out_pc;
    logic              r_skid_valid;
    logic [XLEN-1:0]   r_skid_imm;
    logic [2:0]        r_skid_fmt;
    logic [PC_W-1:0]   r_skid_pc;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_illegal_cnt;

    logic [XLEN+2:0]   w_dec;
    logic [XLEN-1:0]   w_dec_imm;
    logic [2:0]        w_dec_fmt;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_out_free;

    assign w_dec      = f_decode(bus.inst_code);
    assign w_dec_fmt  = w_dec[XLEN+2:XLEN];
    assign w_dec_imm  = w_dec[XLEN-1:0];
    assign w_in_xfer  = bus.in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & bus.out_ready;
    // Output register can take a new entry this edge.
    assign w_out_free = ~r_out_valid | bus.out_ready;

    // Output/skid pipeline registers and the registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= {XLEN{1'b0}};
            r_out_fmt    <= FMT_R;
            r_out_ill    <= 1'b0;
            r_out_pc     <= {PC_W{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_imm   <= {XLEN{1'b0}};
            r_skid_fmt   <= FMT_R;
            r_skid_pc    <= {PC_W{1'b0}};
            r_in_ready   <= 1'b1;
        end else if (bus.flush) begin
            // Any input accepted this cycle is dropped along with both entries.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // in_ready is low while the skid is full, so no input competes.
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_fmt    <= r_skid_fmt;
                r_out_ill    <= (r_skid_fmt == FMT_ILL);
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_xfer) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= w_dec_imm;
                r_out_fmt    <= w_dec_fmt;
                r_out_ill    <= (w_dec_fmt == FMT_ILL);
                r_out_pc     <= bus.pc_in;
                r_in_ready   <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (w_in_xfer) begin
            // Output stalled: park the new entry and close the input.
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_dec_imm;
            r_skid_fmt   <= w_dec_fmt;
            r_skid_pc    <= bus.pc_in;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready   <= ~r_skid_valid;
        end
    end

    // Saturating count of illegal entries handed downstream; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= {CNT_W{1'b0}};
        end else if (bus.cnt_clr) begin
            r_illegal_cnt <= {CNT_W{1'b0}};
        end else if (w_out_xfer && r_out_ill && (r_illegal_cnt != CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_illegal_cnt <= r_illegal_cnt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.imm_out     = r_out_imm;
    assign bus.fmt         = r_out_fmt;
    assign bus.illegal     = r_out_ill;
    assign bus.pc_out      = r_out_pc;
    assign bus.illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_stage.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_stage
// Self-checking bench for imm_gen_stage (XLEN=32). A table of instructions
// with hand-computed immediates and formats is streamed at full rate; a
// scoreboard queue holds the expected entry for every accepted instruction
// and compares it against every delivered entry. Hand-written sequences
// cover backpressure, illegal counting/clear, saturation (second instance
// with CNT_W=2), flush and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .PC_W(32), .CNT_W(16)) bus  ();
    imm_gen_stage_if #(.XLEN(32), .PC_W(32), .CNT_W(2))  bus2 ();

    imm_gen_stage #(.XLEN(32), .PC_W(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    imm_gen_stage #(.XLEN(32), .PC_W(32), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] pc;
    } sb_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    sb_t  sbq  [$];

    logic [31:0] cur_imm;
    logic [2:0]  cur_fmt;
    int total   = 0;
    int bad     = 0;
    int n_deliv = 0;
    int d0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic [31:0] pc);
        bus.in_valid  = 1'b1;
        bus.inst_code = inst;
        bus.pc_in     = pc;
        cur_imm       = imm;
        cur_fmt       = fmt;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.inst_code = 32'h0000_0013;
    endtask

    // Scoreboard: pop/compare on output transfer, push on input transfer.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", {32'd0, bus.pc_out}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb_imm",     {32'd0, bus.imm_out}, {32'd0, e.imm});
                    chk("sb_fmt",     {61'd0, bus.fmt},     {61'd0, e.fmt});
                    chk("sb_illegal", {63'd0, bus.illegal}, {63'd0, (e.fmt == 3'd7)});
                    chk("sb_pc",      {32'd0, bus.pc_out},  {32'd0, e.pc});
                    n_deliv++;
                end
            end
            if (bus.flush) begin
                sbq.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                sbq.push_back('{cur_imm, cur_fmt, bus.pc_in});
            end
        end
    end

    initial begin
        vecs[0]  = '{32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1}; // ADDI x1,x0,-1
        vecs[1]  = '{32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2}; // SW
        vecs[2]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3}; // BEQ -4
        vecs[3]  = '{32'h8000_00B7, 32'h8000_0000, 3'd4}; // LUI
        vecs[4]  = '{32'hFFDF_F0EF, 32'hFFFF_FFFC, 3'd5}; // JAL -4
        vecs[5]  = '{32'h3002_9073, 32'h0000_0300, 3'd6}; // CSRRW mstatus
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 3'd7}; // all zero
        vecs[7]  = '{32'h0000_007F, 32'h0000_0000, 3'd7}; // unknown opcode
        vecs[8]  = '{32'h01F0_9093, 32'h0000_001F, 3'd1}; // SLLI x1,x1,31
        vecs[9]  = '{32'h4050_D093, 32'h0000_0005, 3'd1}; // SRAI x1,x1,5
        vecs[10] = '{32'hFF81_2083, 32'hFFFF_FFF8, 3'd1}; // LW x1,-8(x2)
        vecs[11] = '{32'h0020_80B3, 32'h0000_0000, 3'd0}; // ADD
        vecs[12] = '{32'h0FF0_000F, 32'h0000_0000, 3'd0}; // FENCE
        vecs[13] = '{32'h1234_5097, 32'h1234_5000, 3'd4}; // AUIPC
        vecs[14] = '{32'h0000_0001, 32'h0000_0000, 3'd7}; // compressed encoding
        vecs[15] = '{32'h0040_8067, 32'h0000_0004, 3'd1}; // JALR x0,4(x1)
        vecs[16] = '{32'h0000_0463, 32'h0000_0008, 3'd3}; // BEQ +8

        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.cnt_clr    = 1'b0;
        bus.out_ready  = 1'b0;
        bus.pc_in      = 32'd0;
        cur_imm        = 32'd0;
        cur_fmt        = 3'd0;
        idle();
        bus2.flush     = 1'b0;
        bus2.cnt_clr   = 1'b0;
        bus2.out_ready = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.inst_code = 32'd0;
        bus2.pc_in     = 32'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_imm",       {32'd0, bus.imm_out},   64'd0);
        chk("rst_fmt",       {61'd0, bus.fmt},       64'd0);
        chk("rst_illegal",   {63'd0, bus.illegal},   64'd0);
        chk("rst_pc",        {32'd0, bus.pc_out},    64'd0);
        chk("rst_cnt",       {48'd0, bus.illegal_cnt}, 64'd0);
        rst = 1'b0;

        // Full-rate stream of the vector table.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (i > 0) chk("stream_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
            drive(vecs[i].inst, vecs[i].imm, vecs[i].fmt, 32'h1000 + 32'(4 * i));
        end
        @(negedge clk);
        idle();
        chk("stream_last_valid", {63'd0, bus.out_valid}, 64'd1);
        @(negedge clk);
        chk("stream_drained", {63'd0, bus.out_valid}, 64'd0);
        chk("stream_count", 64'(n_deliv), 64'(NV));
        chk("cnt_after_stream", {48'd0, bus.illegal_cnt}, 64'd3);
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        chk("cnt_clr", {48'd0, bus.illegal_cnt}, 64'd0);

        // Backpressure: three instructions against a stalled output.
        d0 = n_deliv;
        bus.out_ready = 1'b0;
        drive(32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 32'h2000);
        @(negedge clk);
        chk("bp_first_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_ready_after_1", {63'd0, bus.in_ready}, 64'd1);
        drive(32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2, 32'h2004);
        @(negedge clk);
        chk("bp_ready_drop", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_imm_hold", {32'd0, bus.imm_out}, 64'hFFFF_FFFF);
        drive(32'h8000_00B7, 32'h8000_0000, 3'd4, 32'h2008);
        @(negedge clk);
        chk("bp_ready_low", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_stable_imm", {32'd0, bus.imm_out}, 64'hFFFF_FFFF);
        chk("bp_stable_fmt", {61'd0, bus.fmt}, 64'd1);
        chk("bp_stable_pc", {32'd0, bus.pc_out}, 64'h2000);
        chk("bp_none_out", 64'(n_deliv - d0), 64'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_rise", {63'd0, bus.in_ready}, 64'd1);
        chk("bp_skid_to_out", {32'd0, bus.pc_out}, 64'h2004);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        chk("bp_count", 64'(n_deliv - d0), 64'd3);
        chk("bp_sb_empty", 64'(sbq.size()), 64'd0);

        // Illegal counting and clear priority.
        drive(32'h0000_0000, 32'h0, 3'd7, 32'h3000);
        @(negedge clk);
        drive(32'h0000_007F, 32'h0, 3'd7, 32'h3004);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("ill_cnt_two", {48'd0, bus.illegal_cnt}, 64'd2);
        drive(32'h0000_0000, 32'h0, 3'd7, 32'h3008);
        @(negedge clk);
        idle();
        chk("ill_third_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("ill_flag", {63'd0, bus.illegal}, 64'd1);
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        chk("ill_clr_priority", {48'd0, bus.illegal_cnt}, 64'd0);

        // Saturation on the CNT_W=2 instance: five illegals stay at 3.
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.inst_code = 32'h0000_0000;
        repeat (5) @(negedge clk);
        bus2.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_cnt", {62'd0, bus2.illegal_cnt}, 64'd3);
        chk("sat_drained", {63'd0, bus2.out_valid}, 64'd0);

        // Flush with both entries full and an input waiting.
        bus.out_ready = 1'b0;
        drive(32'h8000_00B7, 32'h8000_0000, 3'd4, 32'h4000);
        @(negedge clk);
        drive(32'hFFDF_F0EF, 32'hFFFF_FFFC, 3'd5, 32'h4004);
        @(negedge clk);
        chk("fl_full_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("fl_full_valid", {63'd0, bus.out_valid}, 64'd1);
        drive(32'h3002_9073, 32'h0000_0300, 3'd6, 32'h4008);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, bus.in_ready}, 64'd1);
        // Flush coinciding with an accepted input drops that input too.
        drive(32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 32'h400C);
        @(negedge clk);
        bus.flush = 1'b0;
        idle();
        chk("fl_drop_input", {63'd0, bus.out_valid}, 64'd0);
        chk("fl_ready_after", {63'd0, bus.in_ready}, 64'd1);
        d0 = n_deliv;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("fl_nothing_out", 64'(n_deliv - d0), 64'd0);

        // Asynchronous reset mid-stream.
        drive(32'h0000_007F, 32'h0, 3'd7, 32'h5000);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("ar_cnt_before", {48'd0, bus.illegal_cnt}, 64'd1);
        bus.out_ready = 1'b0;
        drive(32'h8000_00B7, 32'h8000_0000, 3'd4, 32'h5004);
        @(negedge clk);
        idle();
        chk("ar_held_fmt", {61'd0, bus.fmt}, 64'd4);
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("ar_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("ar_imm",       {32'd0, bus.imm_out},   64'd0);
        chk("ar_fmt",       {61'd0, bus.fmt},       64'd0);
        chk("ar_pc",        {32'd0, bus.pc_out},    64'd0);
        chk("ar_cnt",       {48'd0, bus.illegal_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_idle_after", {63'd0, bus.out_valid}, 64'd0);
        chk("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
